divider64: RTL

DIVIDER64 -- requirements
Module: divider64

---
 rtl/divider64.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/divider64.sv
// 64-bit restoring divider: one quotient bit per clock, 64 iterations per operation.
// Build with DIVIDER64_SIGNED_EN defined for two's-complement operands (default: unsigned).
module divider64 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_start,
   input  logic        op_clear,
   input  logic [63:0] dividend,
   input  logic [63:0] divisor,
   output logic [63:0] quotient,
   output logic [63:0] remainder,
   output logic        op_done,
   output logic        div_zero
);

   // state | meaning
   // IDLE  | waiting for op_start; outputs held at zero
   // DIV   | one restoring iteration per edge (or one edge for a zero divisor)
   // DONE  | results valid, held until op_clear
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t        state, state_nxt;
   logic [6:0]    count, count_nxt;
   logic [127:0]  work, work_nxt;
   logic [63:0]   dvs, dvs_nxt;
   logic          dz, dz_nxt;
   logic [63:0]   quotient_nxt, remainder_nxt;
   logic          op_done_nxt, div_zero_nxt;

   logic [63:0]   mag_a, mag_b;
   logic [127:0]  work_sh, work_iter;
   logic [64:0]   sub;
   logic          fits;
   logic [63:0]   q_raw, r_raw, q_fin, r_fin;

   function automatic logic [64:0] cla_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin);
      logic [63:0] g, p, s;
      logic [15:0] gg, gp;
      logic [16:0] gc;
      logic [64:0] c;
      g = a & b;
      p = a ^ b;
      for (int j = 0; j < 16; j++) begin
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
      end
      gc[0] = cin;
      for (int j = 0; j < 16; j++)
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      for (int j = 0; j < 16; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      c[64] = gc[16];
      s     = p ^ c[63:0];
      return {c[64], s};
   endfunction

`ifdef DIVIDER64_SIGNED_EN
   logic neg_q, neg_q_nxt, neg_r, neg_r_nxt;
   assign mag_a = dividend[63] ? -dividend : dividend;
   assign mag_b = divisor[63]  ? -divisor  : divisor;
   assign q_fin = dz ? '1 : (neg_q ? -q_raw : q_raw);
   assign r_fin = neg_r ? -r_raw : r_raw;
`else
   assign mag_a = dividend;
   assign mag_b = divisor;
   assign q_fin = dz ? '1 : q_raw;
   assign r_fin = r_raw;
`endif

   // Bit 127 shifted out means the partial remainder exceeds 2^64, so the subtract always fits.
   assign work_sh   = {work[126:0], 1'b0};
   assign sub       = cla_add(work_sh[127:64], ~dvs, 1'b1);
   assign fits      = sub[64] | work[127];
   assign work_iter = fits ? {sub[63:0], work_sh[63:1], 1'b1} : work_sh;
   assign q_raw     = work_iter[63:0];
   assign r_raw     = dz ? work[63:0] : work_iter[127:64];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (op_clear) state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (op_start) state_nxt = DIV;
            DIV:     if (dz || count == 7'd63) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      work_nxt      = work;
      count_nxt     = count;
      dvs_nxt       = dvs;
      dz_nxt        = dz;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      op_done_nxt   = op_done;
      div_zero_nxt  = div_zero;
`ifdef DIVIDER64_SIGNED_EN
      neg_q_nxt     = neg_q;
      neg_r_nxt     = neg_r;
`endif
      if (op_clear) begin
         work_nxt      = '0;
         count_nxt     = '0;
         dvs_nxt       = '0;
         dz_nxt        = 1'b0;
         quotient_nxt  = '0;
         remainder_nxt = '0;
         op_done_nxt   = 1'b0;
         div_zero_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: if (op_start) begin
               work_nxt  = {64'd0, mag_a};
               dvs_nxt   = mag_b;
               dz_nxt    = (divisor == 64'd0);
               count_nxt = '0;
`ifdef DIVIDER64_SIGNED_EN
               neg_q_nxt = dividend[63] ^ divisor[63];
               neg_r_nxt = dividend[63];
`endif
            end
            DIV: begin
               if (!dz) begin
                  work_nxt  = work_iter;
                  count_nxt = count + 7'd1;
               end
               if (dz || count == 7'd63) begin
                  quotient_nxt  = q_fin;
                  remainder_nxt = r_fin;
                  op_done_nxt   = 1'b1;
                  div_zero_nxt  = dz;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         work      <= '0;
         count     <= '0;
         dvs       <= '0;
         dz        <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         op_done   <= 1'b0;
         div_zero  <= 1'b0;
`ifdef DIVIDER64_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         work      <= work_nxt;
         count     <= count_nxt;
         dvs       <= dvs_nxt;
         dz        <= dz_nxt;
         quotient  <= quotient_nxt;
         remainder <= remainder_nxt;
         op_done   <= op_done_nxt;
         div_zero  <= div_zero_nxt;
`ifdef DIVIDER64_SIGNED_EN
         neg_q     <= neg_q_nxt;
         neg_r     <= neg_r_nxt;
`endif
      end
   end

endmodule
